// File: rtl/ll_sc_resv_monitor.sv
// rtl/ll_sc_resv_monitor.sv - MIPS32 LL/SC reservation monitor between the core MEM stage and data_ram
module ll_sc_resv_monitor #(
    parameter int GRAN_BITS    = 2,
    parameter int RESV_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [1:0]  cpu_op,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_sel,
    input  logic [31:0] cpu_wdata,
    input  logic        excp_clear,
    input  logic        snp_we,
    input  logic [31:0] snp_addr,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        resv_valid,
    output logic [31:0] resv_addr
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LINKED = 1'b1
    } state_t;

    localparam logic [1:0]  OP_LL     = 2'b01;
    localparam logic [1:0]  OP_SC     = 2'b10;
    localparam logic [31:0] GRAN_MASK = ~((32'd1 << GRAN_BITS) - 32'd1);
    localparam bit          TMO_EN    = (RESV_TIMEOUT != 0);
    localparam logic [15:0] TMO_LAST  = (RESV_TIMEOUT == 0) ? 16'd0 : 16'(RESV_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] resv_addr_q, resv_addr_d;
    logic [15:0] timer_q, timer_d;
    logic        ack_q, ack_d;
    logic        is_sc_q, is_sc_d;
    logic        sc_ok_q, sc_ok_d;

    logic linked;
    logic cpu_hit;
    logic snp_hit;
    logic is_ll;
    logic is_sc;
    logic is_norm_store;
    logic sc_ok;

    assign linked        = (state_q == ST_LINKED);
    assign cpu_hit       = ((cpu_addr ^ resv_addr_q) & GRAN_MASK) == 32'd0;
    assign snp_hit       = linked & snp_we & (((snp_addr ^ resv_addr_q) & GRAN_MASK) == 32'd0);
    assign is_ll         = cpu_req & (cpu_op == OP_LL);
    assign is_sc         = cpu_req & (cpu_op == OP_SC);
    // op 2'b11 is reserved and behaves as an ordinary access
    assign is_norm_store = cpu_req & cpu_we & (cpu_op != OP_LL) & (cpu_op != OP_SC);
    assign sc_ok         = linked & cpu_hit & ~snp_hit & ~excp_clear;

    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = 32'd0;
        ram_sel   = 4'd0;
        ram_wdata = 32'd0;
        if (!rst) begin
            ram_ce    = cpu_req;
            ram_we    = cpu_req & cpu_we & (~is_sc | sc_ok);
            ram_addr  = cpu_addr;
            ram_sel   = cpu_sel;
            ram_wdata = cpu_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        resv_addr_d = resv_addr_q;
        timer_d     = timer_q;
        if (excp_clear) begin
            state_d = ST_IDLE;
            timer_d = 16'd0;
        end else if (snp_hit) begin
            state_d = ST_IDLE;
            timer_d = 16'd0;
        end else if (is_sc) begin
            state_d = ST_IDLE;
            timer_d = 16'd0;
        end else if (is_ll) begin
            state_d     = ST_LINKED;
            resv_addr_d = cpu_addr & GRAN_MASK;
            timer_d     = 16'd0;
        end else if (linked && is_norm_store && cpu_hit) begin
            state_d = ST_IDLE;
            timer_d = 16'd0;
        end else if (linked && TMO_EN && (timer_q == TMO_LAST)) begin
            state_d = ST_IDLE;
            timer_d = 16'd0;
        end else if (linked && (timer_q != 16'hFFFF)) begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_comb begin
        ack_d   = cpu_req;
        is_sc_d = is_sc;
        sc_ok_d = is_sc & sc_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            resv_addr_q <= 32'd0;
            timer_q     <= 16'd0;
            ack_q       <= 1'b0;
            is_sc_q     <= 1'b0;
            sc_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            resv_addr_q <= resv_addr_d;
            timer_q     <= timer_d;
            ack_q       <= ack_d;
            is_sc_q     <= is_sc_d;
            sc_ok_q     <= sc_ok_d;
        end
    end

    // ram_rdata arrives the cycle after ram_ce, so load data is muxed in unregistered
    always_comb begin
        cpu_rdata = 32'd0;
        if (ack_q) begin
            cpu_rdata = is_sc_q ? {31'd0, sc_ok_q} : ram_rdata;
        end
    end

    assign cpu_ack    = ack_q;
    assign resv_valid = linked;
    assign resv_addr  = resv_addr_q;

endmodule
